// File: rtl/div32_unit_if.sv
// ---------------------------------------------------------------------------
// div32_unit_if
//   Request/result bundle for the 32-bit iterative divider.
//
//   Request side (driven by master)
//     start       : request pulse, only looked at while the unit is idle
//     signed_op   : 1 = two's-complement divide, 0 = unsigned
//     dividend    : numerator
//     divisor     : denominator
//   Result side (driven by slave)
//     busy        : operation in flight, including the completion cycle
//     done        : single-cycle completion pulse
//     quotient    : registered quotient
//     remainder   : registered remainder
//     div_by_zero : registered flag, set when the captured divisor was 0
// ---------------------------------------------------------------------------
interface div32_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  // Requester: issues operations, observes results.
  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider: accepts operations, produces results.
  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div32_unit.sv
// ---------------------------------------------------------------------------
// div32_unit
//   Iterative restoring divider, one quotient bit per clock, MSB first.
//   Signed operation is done on magnitudes with the signs re-applied at the
//   end, so the quotient truncates toward zero and the remainder takes the
//   sign of the dividend.
//
//   Ports
//     clk    : rising-edge clock for all state
//     n_rst  : asynchronous active-low reset
//     bus    : div32_unit_if.slave (request operands in, results out)
//
//   Timing (accept edge = k, the IDLE edge that sees start=1)
//     k      : raw operands and mode captured
//     k+1    : magnitudes/signs formed, RUN entered (or DONE for divisor 0)
//     k+2 .. k+33 : 32 restoring steps
//     k+33   : RUN -> FIX
//     k+34   : FIX loads the outputs, DONE (done pulse, busy still high)
//     k+35   : DONE -> IDLE
//   busy is high in the 34 cycles following edges k+1..k+34; for a zero
//   divisor only in the single DONE cycle following edge k+1.
// ---------------------------------------------------------------------------
module div32_unit #(
  parameter int WIDTH = 32   // only 32 is supported
) (
  input logic         clk,
  input logic         n_rst,
  div32_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_reg;

  // The accept edge only registers the raw request; the following edge
  // decides between the divide and the divide-by-zero path using the
  // registered copy, keeping the magnitude negation off the input path.
  logic             load_reg;
  logic             signed_reg;
  logic [WIDTH-1:0] dvd_raw_reg;
  logic [WIDTH-1:0] dsr_raw_reg;

  // Working registers. quo_reg starts as the dividend magnitude; each step
  // shifts one dividend bit out of the top and one quotient bit into the
  // bottom, so after WIDTH steps it holds the quotient magnitude.
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dsr_reg;
  logic [WIDTH:0]   rem_reg;
  logic             q_neg_reg;
  logic             r_neg_reg;
  logic [CW-1:0]    cnt_reg;

  // Registered outputs.
  logic             busy_reg;
  logic             done_reg;
  logic             dbz_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;

  // -------------------------------------------------------------------------
  // Operand conditioning: magnitudes and saved signs (signed mode only).
  // -------------------------------------------------------------------------
  logic             dvd_neg;
  logic             dsr_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;

  always_comb begin
    dvd_neg = signed_reg & dvd_raw_reg[WIDTH-1];
    dsr_neg = signed_reg & dsr_raw_reg[WIDTH-1];
    // -2^31 maps onto itself, which is the correct unsigned magnitude.
    dvd_mag = dvd_neg ? (~dvd_raw_reg + 1'b1) : dvd_raw_reg;
    dsr_mag = dsr_neg ? (~dsr_raw_reg + 1'b1) : dsr_raw_reg;
  end

  // -------------------------------------------------------------------------
  // One restoring step. The partial remainder is always below the divisor,
  // so the shifted value is below 2*divisor and fits in WIDTH+1 bits; the
  // top bit of the trial difference is therefore an exact borrow flag.
  // -------------------------------------------------------------------------
  logic [WIDTH:0]   shift_rem;
  logic [WIDTH:0]   trial;
  logic             borrow;

  always_comb begin
    shift_rem = {rem_reg[WIDTH-1:0], quo_reg[WIDTH-1]};
    trial     = shift_rem - {1'b0, dsr_reg};
    borrow    = trial[WIDTH];
  end

  // -------------------------------------------------------------------------
  // Sign fix-up. q_neg_reg/r_neg_reg are already gated by the signed mode.
  // -2^31 / -1 yields magnitude 2^31 with a positive sign, which reads back
  // as 0x80000000: the wrapped result wanted for that overflow case.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  always_comb begin
    q_fix = q_neg_reg ? (~quo_reg + 1'b1) : quo_reg;
    r_fix = r_neg_reg ? (~rem_reg[WIDTH-1:0] + 1'b1) : rem_reg[WIDTH-1:0];
  end

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg     <= IDLE;
      load_reg      <= 1'b0;
      signed_reg    <= 1'b0;
      dvd_raw_reg   <= '0;
      dsr_raw_reg   <= '0;
      quo_reg       <= '0;
      dsr_reg       <= '0;
      rem_reg       <= '0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      cnt_reg       <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      dbz_reg       <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (load_reg) begin
            // Dispatch the request captured on the previous edge.
            load_reg <= 1'b0;
            busy_reg <= 1'b1;
            if (dsr_raw_reg == '0) begin
              state_reg     <= DONE;
              done_reg      <= 1'b1;
              dbz_reg       <= 1'b1;
              quotient_reg  <= '1;
              remainder_reg <= dvd_raw_reg;
            end else begin
              state_reg <= RUN;
              quo_reg   <= dvd_mag;
              dsr_reg   <= dsr_mag;
              rem_reg   <= '0;
              cnt_reg   <= '0;
              q_neg_reg <= dvd_neg ^ dsr_neg;
              r_neg_reg <= dvd_neg;
            end
          end else if (bus.start) begin
            load_reg    <= 1'b1;
            signed_reg  <= bus.signed_op;
            dvd_raw_reg <= bus.dividend;
            dsr_raw_reg <= bus.divisor;
            if (bus.divisor != '0) begin
              dbz_reg <= 1'b0;
            end
          end
        end

        RUN: begin
          rem_reg <= borrow ? shift_rem : trial;
          quo_reg <= {quo_reg[WIDTH-2:0], ~borrow};
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(WIDTH - 1)) begin
            state_reg <= FIX;
          end
        end

        FIX: begin
          quotient_reg  <= q_fix;
          remainder_reg <= r_fix;
          done_reg      <= 1'b1;
          state_reg     <= DONE;
        end

        DONE: begin
          // start is not looked at here; the next request needs IDLE.
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_div32_unit.sv
// ---------------------------------------------------------------------------
// tb_div32_unit
//   Directed bench for div32_unit. A transaction-level model predicts the
//   result of each accepted request with plain integer arithmetic and the
//   cycle on which it must appear; a compare process checks every output on
//   every cycle against it, and checks hand-computed values at each done.
// ---------------------------------------------------------------------------
module tb_div32_unit;

  logic clk = 1'b0;
  logic n_rst = 1'b0;

  always #5 clk = ~clk;

  div32_unit_if #(.WIDTH(32)) dif ();

  div32_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (dif)
  );

  // Hand-computed expectations for the request being issued.
  logic [31:0] lit_q;
  logic [31:0] lit_r;
  bit          lit_z;
  int          lit_lat;
  bit          lit_ok;

  // ---------------------------------------------------------------- model
  bit          m_active;
  int          m_el;        // clock edges since the accept edge
  int          m_lat;       // edges from accept to the done cycle
  bit          m_s;
  logic [31:0] m_a, m_b;
  logic [31:0] m_q, m_r;
  bit          m_z;
  logic [31:0] m_lit_q, m_lit_r;
  bit          m_lit_z;
  int          m_lit_lat;
  bit          m_lit_ok;
  logic [31:0] exp_q, exp_r;
  bit          exp_z;

  function automatic void predict(input bit s, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] q,
                                  output logic [31:0] r, output bit z);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      z  = 1'b0;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_active = 1'b0;
      m_el     = 0;
      m_lat    = 0;
      m_lit_ok = 1'b0;
      exp_q    = '0;
      exp_r    = '0;
      exp_z    = 1'b0;
    end else if (m_active) begin
      m_el = m_el + 1;
      if (m_el > m_lat) begin
        m_active = 1'b0;
      end else if (m_el == m_lat) begin
        exp_q = m_q;
        exp_r = m_r;
        exp_z = m_z;
      end
    end else if (dif.start) begin
      m_active  = 1'b1;
      m_el      = 0;
      m_s       = dif.signed_op;
      m_a       = dif.dividend;
      m_b       = dif.divisor;
      predict(m_s, m_a, m_b, m_q, m_r, m_z);
      m_lat     = (m_b == 32'd0) ? 1 : 34;
      if (m_b != 32'd0) exp_z = 1'b0;
      m_lit_q   = lit_q;
      m_lit_r   = lit_r;
      m_lit_z   = lit_z;
      m_lit_lat = lit_lat;
      m_lit_ok  = lit_ok;
    end
  end

  // -------------------------------------------------------------- compare
  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt = 0;
  int txn_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(negedge clk or negedge n_rst) begin
    bit e_busy, e_done;
    #1;
    e_busy = m_active && (m_el >= 1);
    e_done = m_active && (m_el == m_lat);
    chk("busy", 32'(dif.busy), 32'(e_busy));
    chk("done", 32'(dif.done), 32'(e_done));
    chk("quotient", dif.quotient, exp_q);
    chk("remainder", dif.remainder, exp_r);
    chk("div_by_zero", 32'(dif.div_by_zero), 32'(exp_z));
    if (!n_rst) begin
      busy_cnt = 0;
    end else begin
      if (dif.busy === 1'b1) busy_cnt++;
      if (e_done) begin
        txn_cnt++;
        $display("txn %0d: %s %h / %h -> q=%h r=%h dbz=%0d busy_cycles=%0d",
                 txn_cnt, m_s ? "signed" : "unsigned", m_a, m_b,
                 dif.quotient, dif.remainder, dif.div_by_zero, busy_cnt);
        if (m_lit_ok) begin
          chk("lit_quotient", dif.quotient, m_lit_q);
          chk("lit_remainder", dif.remainder, m_lit_r);
          chk("lit_div_by_zero", 32'(dif.div_by_zero), 32'(m_lit_z));
          chk("lit_busy_cycles", 32'(busy_cnt), 32'(m_lit_lat));
        end
        busy_cnt = 0;
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  typedef struct {
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    bit          z;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV] = '{
    '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0},
    '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0},
    '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0},
    '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1},
    '{1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1},
    '{1'b0, 32'd20,         32'd6,          32'd3,          32'd2,          1'b0},
    '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0},
    '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0},
    '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0},
    '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0},
    '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0},
    '{1'b1, 32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          1'b0},
    '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0}
  };

  // Issue one request (called one time unit after a rising edge while the
  // unit is idle) and return one time unit after the edge that brings the
  // unit back to IDLE. Operand buses are scrambled while it works.
  task automatic op(input bit s, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] q, input logic [31:0] r, input bit z);
    lit_q     = q;
    lit_r     = r;
    lit_z     = z;
    lit_lat   = z ? 1 : 34;
    lit_ok    = 1'b1;
    dif.start     = 1'b1;
    dif.signed_op = s;
    dif.dividend  = a;
    dif.divisor   = b;
    @(posedge clk); #1;
    dif.start = 1'b0;
    for (int c = 0; c < lit_lat + 1; c++) begin
      dif.dividend  = $urandom;
      dif.divisor   = $urandom;
      dif.signed_op = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    dif.start     = 1'b0;
    dif.signed_op = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;
    lit_q = '0; lit_r = '0; lit_z = 1'b0; lit_lat = 0; lit_ok = 1'b0;

    repeat (3) @(posedge clk);
    #3 n_rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z);
    end

    // 5/1 with a stray start (9/3) in the middle of RUN, buses toggling,
    // and start held high in the DONE cycle: exactly one result expected.
    lit_q = 32'd5; lit_r = 32'd0; lit_z = 1'b0; lit_lat = 34; lit_ok = 1'b1;
    dif.start = 1'b1; dif.signed_op = 1'b0;
    dif.dividend = 32'd5; dif.divisor = 32'd1;
    @(posedge clk); #1;
    for (int c = 1; c <= 34; c++) begin
      if (c == 10) begin
        dif.start = 1'b1; dif.dividend = 32'd9; dif.divisor = 32'd3;
      end else begin
        dif.start = 1'b0; dif.dividend = $urandom; dif.divisor = $urandom;
      end
      dif.signed_op = 1'($urandom);
      @(posedge clk); #1;
    end
    dif.start = 1'b1; dif.dividend = 32'd77; dif.divisor = 32'd0;
    @(posedge clk); #1;
    dif.start = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of RUN: outputs clear at once, no done follows.
    lit_q = 32'd333; lit_r = 32'd1; lit_z = 1'b0; lit_lat = 34; lit_ok = 1'b1;
    dif.start = 1'b1; dif.signed_op = 1'b0;
    dif.dividend = 32'd1000; dif.divisor = 32'd3;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (15) @(posedge clk);
    #3 n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #3 n_rst = 1'b1;
    @(posedge clk); #1;
    op(1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div32_unit.md
DIV32_UNIT -- requirements
Module: div32_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; only 32 is supported.
REQ-002 Port: clk  in  1  rising-edge clock for all state.
REQ-003 Port: n_rst  in  1  reset, asynchronous, active-low.
REQ-004 Port: start  in  1  request; sampled only in IDLE.
REQ-005 Port: signed_op  in  1  1 = two's-complement divide, 0 = unsigned; captured with start.
REQ-006 Port: dividend  in  WIDTH  numerator; captured with start.
REQ-007 Port: divisor  in  WIDTH  denominator; captured with start.
REQ-008 Port: busy  out  1  high from the cycle after start is accepted through the DONE cycle, inclusive.
REQ-009 Port: done  out  1  single-cycle completion pulse.
REQ-010 Port: quotient  out  WIDTH  result quotient, registered.
REQ-011 Port: remainder  out  WIDTH  result remainder, registered.
REQ-012 Port: div_by_zero  out  1  registered flag; set when the captured divisor is 0.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, FIX, DONE.
- IDLE: start=1 -> RUN, or DONE if divisor==0.
- RUN: exit to FIX after WIDTH iterations.
- FIX -> DONE.
- DONE -> IDLE.
REQ-014 On accept, operands SHALL be captured; in signed mode magnitudes are taken, and the quotient sign (dividend[31]^divisor[31]) and remainder sign (dividend[31]) are saved.
REQ-015 RUN SHALL perform one restoring-division step per cycle, MSB first.
- 33-bit partial remainder: shift left, bring in the next dividend bit, trial-subtract the divisor magnitude.
- Quotient bit = NOT borrow; restore on borrow.
- Iteration counter: 0..WIDTH-1.
REQ-016 FIX SHALL negate the quotient and/or remainder magnitudes per the saved signs (signed mode only), then load the quotient/remainder outputs.
REQ-017 Latency: start accepted at edge k -> done=1 in the cycle following edge k+WIDTH+2 (34 cycles for WIDTH=32); divide-by-zero -> done=1 in the cycle following edge k+1.
REQ-018 done SHALL be high only in DONE; quotient, remainder and div_by_zero SHALL be stable from DONE until the next accepted start.
REQ-019 start while busy=1 SHALL be ignored with no effect on the operation in progress; start high in the DONE cycle is also ignored.
REQ-020 Divide by zero SHALL give quotient = all ones, remainder = dividend, div_by_zero = 1, in both modes.
REQ-021 Signed -2^31 / -1 SHALL give quotient = 0x80000000, remainder = 0, with no flag.
REQ-022 div_by_zero SHALL be cleared on every accepted start with a nonzero divisor.
REQ-023 Operands SHALL be captured once at accept; input changes during busy SHALL NOT affect results.
REQ-024 Results SHALL satisfy dividend = quotient*divisor + remainder (mod 2^WIDTH), with |remainder| < |divisor| for all nonzero divisors.

Reset
REQ-025 n_rst low SHALL immediately force state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and clear the counter and internal registers, including mid-RUN.
REQ-026 After n_rst deasserts, the first rising edge with start=1 SHALL begin a new operation normally; no partial result survives reset.

Verification
REQ-027 Unsigned 100/7 -> done after 34 cycles; quotient=14, remainder=2, div_by_zero=0; busy high for exactly 34 cycles.
REQ-028 Signed -7/2 (0xFFFFFFF9/2) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); signed 7/-2 -> quotient=-3, remainder=1.
REQ-029 Divisor 0, dividend 0x12345678, both modes -> done 2 cycles after start; quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1.
REQ-030 Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0; unsigned 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
REQ-031 start 5/1, then start pulsed at cycle 10 with operands 9/3 and input buses toggled during RUN -> single done, quotient=5, remainder=0.
REQ-032 n_rst asserted at RUN cycle 15 -> all outputs 0 at once, no done; after release, 20/6 -> quotient=3, remainder=2.
